// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one UART TX byte path
module uart_tx_arbiter #(
  parameter  int NUM_REQ        = 2,
  parameter  int DATA_W         = 8,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int GID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        s_valid,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic                      m_valid,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_ready,
  output logic                      busy,
  output logic [GID_W-1:0]          grant_id,
  output logic                      timeout_pulse
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Counter only needs to hold TIMEOUT_CYCLES-1; expiry is detected one step early.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GID_W:0]   NREQ_W     = (GID_W + 1)'(NUM_REQ);
  localparam logic [GID_W-1:0] LAST_RESET = GID_W'(NUM_REQ - 1);

  logic [0:0]       state_q, state_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  logic             pick_found;
  logic [GID_W-1:0] pick_id;
  logic [GID_W:0]   cand;
  logic             sel_valid;
  logic             sel_last;
  logic [DATA_W-1:0] sel_data;
  logic             in_grant;

  assign in_grant      = (state_q == ST_GRANT);
  assign busy          = in_grant;
  assign grant_id      = grant_q;
  assign timeout_pulse = pulse_q;

  // Round-robin pick: first valid requester after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (GID_W + 1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_found && s_valid[j] && (cand == (GID_W + 1)'(j))) begin
          pick_found = 1'b1;
          pick_id    = GID_W'(j);
        end
      end
    end
  end

  // Select the granted requester's stream and steer m_ready back only to it.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    s_ready   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_q == GID_W'(j)) begin
        sel_valid  = s_valid[j];
        sel_last   = s_last[j];
        sel_data   = s_data[j*DATA_W +: DATA_W];
        s_ready[j] = in_grant & m_ready;
      end
    end
    m_valid = in_grant & sel_valid;
    m_data  = sel_data;
  end

  // Next-state: grant on arbitration, release on last beat or watchdog expiry.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    pulse_d      = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (pick_found) begin
        state_d      = ST_GRANT;
        grant_d      = pick_id;
        last_grant_d = pick_id;
      end
    end else begin
      if (sel_valid) begin
        // A stalled UART with data pending is not a requester stall.
        cnt_d = '0;
        if (m_ready && sel_last) state_d = ST_IDLE;
      end else if (TIMEOUT_CYCLES > 0) begin
        if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RESET;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Shared stimulus for the two 2-requester instances
  logic [1:0]  s_valid = '0;
  logic [15:0] s_data  = '0;
  logic [1:0]  s_last  = '0;
  logic        m_ready = 1'b0;

  logic [1:0]  a_s_ready, b_s_ready;
  logic        a_m_valid, b_m_valid;
  logic [7:0]  a_m_data,  b_m_data;
  logic        a_busy,    b_busy;
  logic        a_gid,     b_gid;
  logic        a_pulse,   b_pulse;

  // 3-requester instance
  logic [2:0]  c_valid   = '0;
  logic [23:0] c_data    = '0;
  logic [2:0]  c_last    = '0;
  logic        c_m_ready = 1'b0;
  logic [2:0]  c_s_ready;
  logic        c_m_valid;
  logic [7:0]  c_m_data;
  logic        c_busy;
  logic [1:0]  c_gid;
  logic        c_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(a_s_ready), .m_valid(a_m_valid), .m_data(a_m_data), .m_ready(m_ready),
    .busy(a_busy), .grant_id(a_gid), .timeout_pulse(a_pulse)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(b_s_ready), .m_valid(b_m_valid), .m_data(b_m_data), .m_ready(m_ready),
    .busy(b_busy), .grant_id(b_gid), .timeout_pulse(b_pulse)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .TIMEOUT_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .s_valid(c_valid), .s_data(c_data), .s_last(c_last),
    .s_ready(c_s_ready), .m_valid(c_m_valid), .m_data(c_m_data), .m_ready(c_m_ready),
    .busy(c_busy), .grant_id(c_gid), .timeout_pulse(c_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] l, input logic mr);
    s_valid = v;
    s_data  = {d1, d0};
    s_last  = l;
    m_ready = mr;
  endtask

  initial begin
    // Reset state
    drive(2'b11, 8'hA1, 8'hB1, 2'b00, 1'b1);
    #1;
    chk("rst_busy",    32'(a_busy),    32'h0);
    chk("rst_gid",     32'(a_gid),     32'h0);
    chk("rst_m_valid", 32'(a_m_valid), 32'h0);
    chk("rst_s_ready", 32'(a_s_ready), 32'h0);
    chk("rst_pulse",   32'(a_pulse),   32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Test 1: both valid from reset, A packet then B packet
    chk("t1_idle0", 32'(a_m_valid), 32'h0);
    tick();
    chk("t1_a1_valid", 32'(a_m_valid), 32'h1);
    chk("t1_a1_data",  32'(a_m_data),  32'hA1);
    chk("t1_a1_gid",   32'(a_gid),     32'h0);
    chk("t1_a1_ready", 32'(a_s_ready), 32'h1);
    chk("t1_a1_busy",  32'(a_busy),    32'h1);
    tick(); drive(2'b11, 8'hA2, 8'hB1, 2'b00, 1'b1); #1;
    chk("t1_a2_data", 32'(a_m_data), 32'hA2);
    tick(); drive(2'b11, 8'hA3, 8'hB1, 2'b01, 1'b1); #1;
    chk("t1_a3_data", 32'(a_m_data), 32'hA3);
    tick(); drive(2'b10, 8'h00, 8'hB1, 2'b00, 1'b1); #1;
    chk("t1_gap_valid", 32'(a_m_valid), 32'h0);
    chk("t1_gap_busy",  32'(a_busy),    32'h0);
    chk("t1_gap_gid",   32'(a_gid),     32'h0);
    tick();
    chk("t1_b1_data",  32'(a_m_data),  32'hB1);
    chk("t1_b1_gid",   32'(a_gid),     32'h1);
    chk("t1_b1_ready", 32'(a_s_ready), 32'h2);
    tick(); drive(2'b10, 8'h00, 8'hB2, 2'b00, 1'b1); #1;
    chk("t1_b2_data", 32'(a_m_data), 32'hB2);
    tick(); drive(2'b10, 8'h00, 8'hB3, 2'b10, 1'b1); #1;
    chk("t1_b3_data", 32'(a_m_data), 32'hB3);
    tick(); drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); #1;
    chk("t1_end_busy", 32'(a_busy), 32'h0);
    chk("t1_end_gid",  32'(a_gid),  32'h1);

    // Test 2: req1 alone, two back-to-back 2-byte packets
    tick(); drive(2'b10, 8'h00, 8'hC1, 2'b00, 1'b1); #1;
    chk("t2_idle", 32'(a_m_valid), 32'h0);
    tick();
    chk("t2_c1_data",  32'(a_m_data),  32'hC1);
    chk("t2_c1_gid",   32'(a_gid),     32'h1);
    chk("t2_c1_ready", 32'(a_s_ready), 32'h2);
    tick(); drive(2'b10, 8'h00, 8'hC2, 2'b10, 1'b1); #1;
    chk("t2_c2_data", 32'(a_m_data), 32'hC2);
    tick(); drive(2'b10, 8'h00, 8'hD1, 2'b00, 1'b1); #1;
    chk("t2_gap_valid", 32'(a_m_valid), 32'h0);
    chk("t2_gap_ready", 32'(a_s_ready), 32'h0);
    tick();
    chk("t2_d1_data",  32'(a_m_data),  32'hD1);
    chk("t2_d1_gid",   32'(a_gid),     32'h1);
    chk("t2_d1_valid", 32'(a_m_valid), 32'h1);
    tick(); drive(2'b10, 8'h00, 8'hD2, 2'b10, 1'b1); #1;
    chk("t2_d2_data",  32'(a_m_data),  32'hD2);
    chk("t2_d2_ready", 32'(a_s_ready), 32'h2);
    tick(); drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); #1;
    chk("t2_end_busy", 32'(a_busy), 32'h0);

    // Test 3: UART stall under a req0 grant, watchdog must stay quiet
    tick(); drive(2'b01, 8'hE1, 8'h00, 2'b00, 1'b0); #1;
    chk("t3_idle", 32'(a_m_valid), 32'h0);
    tick();
    chk("t3_valid", 32'(a_m_valid), 32'h1);
    chk("t3_data",  32'(a_m_data),  32'hE1);
    chk("t3_ready", 32'(a_s_ready), 32'h0);
    chk("t3_busy",  32'(a_busy),    32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_stall_valid",   32'(a_m_valid), 32'h1);
      chk("t3_stall_data",    32'(a_m_data),  32'hE1);
      chk("t3_stall_ready",   32'(a_s_ready), 32'h0);
      chk("t3_stall_pulse_a", 32'(a_pulse),   32'h0);
      chk("t3_stall_pulse_b", 32'(b_pulse),   32'h0);
    end
    drive(2'b01, 8'hE1, 8'h00, 2'b01, 1'b1); #1;
    chk("t3_release_ready", 32'(a_s_ready), 32'h1);
    tick(); drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); #1;
    chk("t3_end_busy",  32'(a_busy),  32'h0);
    chk("t3_end_pulse", 32'(a_pulse), 32'h0);

    // Test 4: req0 stalls mid-packet, 16-cycle watchdog hands over to req1
    tick(); drive(2'b01, 8'h55, 8'h00, 2'b00, 1'b1); #1;
    tick();
    chk("t4_55_gid",   32'(b_gid),     32'h0);
    chk("t4_55_data",  32'(b_m_data),  32'h55);
    chk("t4_55_valid", 32'(b_m_valid), 32'h1);
    tick(); drive(2'b10, 8'h00, 8'hF1, 2'b10, 1'b1); #1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_wait_pulse", 32'(b_pulse),   32'h0);
      chk("t4_wait_busy",  32'(b_busy),    32'h1);
      chk("t4_wait_valid", 32'(b_m_valid), 32'h0);
      tick();
    end
    chk("t4_pulse",       32'(b_pulse),   32'h1);
    chk("t4_pulse_busy",  32'(b_busy),    32'h0);
    chk("t4_pulse_ready", 32'(b_s_ready), 32'h0);
    tick();
    chk("t4_after_pulse", 32'(b_pulse),   32'h0);
    chk("t4_req1_gid",    32'(b_gid),     32'h1);
    chk("t4_req1_data",   32'(b_m_data),  32'hF1);
    chk("t4_req1_ready",  32'(b_s_ready), 32'h2);
    tick(); drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); #1;

    // Test 5: reset mid-packet after two of four bytes
    repeat (6) tick();
    chk("t5_pre_busy", 32'(a_busy), 32'h0);
    drive(2'b01, 8'h61, 8'h00, 2'b00, 1'b1); #1;
    tick();
    chk("t5_g1_gid",  32'(a_gid),    32'h0);
    chk("t5_g1_data", 32'(a_m_data), 32'h61);
    tick(); drive(2'b01, 8'h62, 8'h00, 2'b00, 1'b1); #1;
    chk("t5_g2_data", 32'(a_m_data), 32'h62);
    tick(); drive(2'b01, 8'h63, 8'h00, 2'b00, 1'b1); #1;
    chk("t5_g3_data", 32'(a_m_data), 32'h63);
    rst = 1'b1;
    drive(2'b11, 8'h63, 8'h71, 2'b00, 1'b1); #1;
    chk("t5_rst_valid", 32'(a_m_valid), 32'h0);
    chk("t5_rst_ready", 32'(a_s_ready), 32'h0);
    chk("t5_rst_busy",  32'(a_busy),    32'h0);
    tick();
    tick();
    rst = 1'b0; #1;
    chk("t5_post_idle", 32'(a_m_valid), 32'h0);
    tick();
    chk("t5_post_gid",   32'(a_gid),     32'h0);
    chk("t5_post_data",  32'(a_m_data),  32'h63);
    chk("t5_post_ready", 32'(a_s_ready), 32'h1);
    drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); #1;

    // Test 6: three requesters with continuous single-byte packets
    c_valid   = 3'b111;
    c_last    = 3'b111;
    c_data    = {8'hC2, 8'hC1, 8'hC0};
    c_m_ready = 1'b1;
    #1;
    chk("t6_idle0", 32'(c_m_valid), 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_gid",   32'(c_gid),     32'(k % 3));
      chk("t6_data",  32'(c_m_data),  32'(8'hC0 + (k % 3)));
      chk("t6_ready", 32'(c_s_ready), 32'(1 << (k % 3)));
      chk("t6_busy",  32'(c_busy),    32'h1);
      tick();
      chk("t6_gap_valid", 32'(c_m_valid), 32'h0);
      chk("t6_gap_busy",  32'(c_busy),    32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
